// File: rtl/tx_fifo_drain_pkg.sv
// tx_fifo_drain_pkg: shared definitions for tx_fifo_drain.
//   state_t          - drain FSM state encoding
//   TX_DATA_RST_BIT  - bit value replicated to form the TX_DATA reset word
package tx_fifo_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  localparam logic TX_DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/tx_fifo_drain.sv
// tx_fifo_drain: pops one word at a time from a FIFO and hands it to a
// transmitter with a start pulse, waiting for the transmitter's busy
// handshake. If busy never rises within BUSY_TIMEOUT cycles the same word is
// reissued (no new pop).
//
// Ports
//   CLK, RST     - clock, synchronous active-high reset
//   EN           - drain enable, sampled in IDLE only
//   FIFO_EMPTY   - FIFO read-side empty flag
//   FIFO_RDATA   - FIFO head word
//   FIFO_RINC    - pop strobe (high in POP)
//   TX_BUSY      - transmitter busy
//   TX_DATA      - registered word for the transmitter
//   TX_VALID     - start pulse (high in ISSUE)
//   DRAIN_IDLE   - high in IDLE
//   WORD_CNT     - count of words accepted by the transmitter
//
// Build option: define TX_FIFO_DRAIN_CNT_EN to add the WORD_CNT port and its
// counter (width CNT_WIDTH, wraps).
module tx_fifo_drain
  import tx_fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RDATA,
  output logic                  FIFO_RINC,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  output logic                  DRAIN_IDLE
`ifdef TX_FIFO_DRAIN_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  WORD_CNT
`endif
);

  localparam int            TW      = $clog2(BUSY_TIMEOUT);
  // The counter runs 0..BUSY_TIMEOUT-1 in WAIT_BUSY, so a reissue follows
  // ISSUE by BUSY_TIMEOUT+1 cycles.
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  if (BUSY_TIMEOUT < 2 || BUSY_TIMEOUT > 255 || CNT_WIDTH < 1) begin : g_bad_param
    $error("tx_fifo_drain: BUSY_TIMEOUT must be 2..255 and CNT_WIDTH >= 1");
  end

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (EN && !FIFO_EMPTY) state_d = ST_POP;
      end
      ST_POP: begin
        // The only place TX_DATA changes; reissues reuse the held word.
        tx_data_d = FIFO_RDATA;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (TX_BUSY)                   state_d  = ST_WAIT_DONE;
        else if (to_cnt_q == TO_LAST)  state_d  = ST_ISSUE;
        else                           to_cnt_d = to_cnt_q + TW'(1);
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tx_data_q <= {DATA_WIDTH{TX_DATA_RST_BIT}};
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Moore outputs decoded straight from the state register.
  assign FIFO_RINC  = (state_q == ST_POP);
  assign TX_VALID   = (state_q == ST_ISSUE);
  assign DRAIN_IDLE = (state_q == ST_IDLE);
  assign TX_DATA    = tx_data_q;

`ifdef TX_FIFO_DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  // A word counts as accepted when busy is seen in WAIT_BUSY.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (state_q == ST_WAIT_BUSY && TX_BUSY) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end

  assign WORD_CNT = word_cnt_q;
`endif

endmodule
